// File: rtl/alu_issue_stage_if.sv
// ============================================================================
//  Module      : alu_issue_stage_if
//  Description : Upstream issue, ALU drive/return and retire signals of the
//                ALU issue stage, bundled with master/slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_is_branch;
    logic        out_taken;
    logic        out_illegal;

    modport slave (
        input  in_valid, opcode, funct3, funct7_5, rs1_val, rs2_val, imm,
        input  alu_result, alu_zero, out_ready,
        output in_ready, alu_a, alu_b, alu_ctrl,
        output out_valid, out_result, out_is_branch, out_taken, out_illegal
    );

    modport master (
        output in_valid, opcode, funct3, funct7_5, rs1_val, rs2_val, imm,
        output alu_result, alu_zero, out_ready,
        input  in_ready, alu_a, alu_b, alu_ctrl,
        input  out_valid, out_result, out_is_branch, out_taken, out_illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Two-stage RV32I issue/retire wrapper around a single-cycle
//                ALU: decode + operand registers, then result/branch capture.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_stage (
    input  wire logic        clk,
    input  wire logic        reset,
    alu_issue_stage_if.slave bus
);

    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    localparam logic [3:0] c_alu_add = 4'b0000;
    localparam logic [3:0] c_alu_sub = 4'b0001;
    localparam logic [3:0] c_alu_and = 4'b0010;
    localparam logic [3:0] c_alu_or  = 4'b0011;
    localparam logic [3:0] c_alu_xor = 4'b0100;
    localparam logic [3:0] c_alu_sll = 4'b0101;
    localparam logic [3:0] c_alu_srl = 4'b0110;
    localparam logic [3:0] c_alu_sra = 4'b0111;
    localparam logic [3:0] c_alu_slt = 4'b1000;

    logic [3:0]  w_ctrl;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_is_branch;
    logic        w_br_inv;
    logic        w_illegal;
    logic        w_accept;
    logic        w_s2_load;

    logic        r_s1_valid;
    logic [3:0]  r_s1_ctrl;
    logic [31:0] r_s1_a;
    logic [31:0] r_s1_b;
    logic        r_s1_is_branch;
    logic        r_s1_br_inv;
    logic        r_s1_illegal;

    logic        r_s2_valid;
    logic [31:0] r_s2_result;
    logic        r_s2_is_branch;
    logic        r_s2_taken;
    logic        r_s2_illegal;

    // w_br_inv selects taken = !zero (BNE, BLT) instead of taken = zero.
    always_comb begin
        w_ctrl      = c_alu_add;
        w_a         = bus.rs1_val;
        w_b         = bus.rs2_val;
        w_is_branch = 1'b0;
        w_br_inv    = 1'b0;
        w_illegal   = 1'b0;
        case (bus.opcode)
            c_op_reg, c_op_imm: begin
                if (bus.opcode == c_op_imm) begin
                    w_b = bus.imm;
                end
                case (bus.funct3)
                    3'b000: w_ctrl = (bus.funct7_5 && bus.opcode == c_op_reg) ? c_alu_sub : c_alu_add;
                    3'b001: w_ctrl = c_alu_sll;
                    3'b010: w_ctrl = c_alu_slt;
                    3'b100: w_ctrl = c_alu_xor;
                    3'b101: w_ctrl = bus.funct7_5 ? c_alu_sra : c_alu_srl;
                    3'b110: w_ctrl = c_alu_or;
                    3'b111: w_ctrl = c_alu_and;
                    default: w_illegal = 1'b1;
                endcase
            end
            c_op_load, c_op_store: begin
                w_b = bus.imm;
            end
            c_op_lui: begin
                w_a = 32'd0;
                w_b = bus.imm;
            end
            c_op_branch: begin
                w_is_branch = 1'b1;
                case (bus.funct3)
                    3'b000: w_ctrl = c_alu_sub;
                    3'b001: begin w_ctrl = c_alu_sub; w_br_inv = 1'b1; end
                    3'b100: begin w_ctrl = c_alu_slt; w_br_inv = 1'b1; end
                    3'b101: w_ctrl = c_alu_slt;
                    default: w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_ctrl      = c_alu_add;
            w_a         = 32'd0;
            w_b         = 32'd0;
            w_is_branch = 1'b0;
            w_br_inv    = 1'b0;
        end
    end

    assign w_s2_load    = r_s1_valid && (!r_s2_valid || bus.out_ready);
    assign bus.in_ready = !reset && (!r_s1_valid || !r_s2_valid || bus.out_ready);
    assign w_accept     = bus.in_valid && bus.in_ready;

    // alu_* hold their last values while stage 1 is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid     <= 1'b0;
            r_s1_ctrl      <= c_alu_add;
            r_s1_a         <= 32'd0;
            r_s1_b         <= 32'd0;
            r_s1_is_branch <= 1'b0;
            r_s1_br_inv    <= 1'b0;
            r_s1_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid     <= 1'b1;
            r_s1_ctrl      <= w_ctrl;
            r_s1_a         <= w_a;
            r_s1_b         <= w_b;
            r_s1_is_branch <= w_is_branch;
            r_s1_br_inv    <= w_br_inv;
            r_s1_illegal   <= w_illegal;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid     <= 1'b0;
            r_s2_result    <= 32'd0;
            r_s2_is_branch <= 1'b0;
            r_s2_taken     <= 1'b0;
            r_s2_illegal   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid     <= 1'b1;
            r_s2_result    <= r_s1_illegal ? 32'd0 : bus.alu_result;
            r_s2_is_branch <= r_s1_is_branch;
            r_s2_taken     <= r_s1_is_branch && (bus.alu_zero ^ r_s1_br_inv);
            r_s2_illegal   <= r_s1_illegal;
        end else if (bus.out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign bus.alu_a         = r_s1_a;
    assign bus.alu_b         = r_s1_b;
    assign bus.alu_ctrl      = r_s1_ctrl;
    assign bus.out_valid     = r_s2_valid;
    assign bus.out_result    = r_s2_result;
    assign bus.out_is_branch = r_s2_is_branch;
    assign bus.out_taken     = r_s2_taken;
    assign bus.out_illegal   = r_s2_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
//  Module      : tb_alu_issue_stage
//  Description : Table-driven scoreboard bench for alu_issue_stage with a
//                behavioural ALU closing the loop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        br;
        logic        tk;
        logic        ill;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    bit   rdy_pat[$];

    int   total = 0;
    int   bad = 0;
    int   inflight = 0;
    bit   retire_pending = 0;
    bit   held_valid = 0;
    bit   stall_full = 0;
    logic [31:0] h_res;
    logic        h_br, h_tk, h_ill;
    logic [31:0] s_a, s_b;
    logic [3:0]  s_c;

    function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0101: return a << b[4:0];
            4'b0110: return a >> b[4:0];
            4'b0111: return $unsigned($signed(a) >>> b[4:0]);
            4'b1000: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign bus.alu_result = alu_model(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    assign bus.alu_zero   = (bus.alu_result == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic [3:0] ctrl, input logic [31:0] res,
                                input logic br, input logic tk, input logic ill);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.imm = imm;
        v.ctrl = ctrl; v.res = res; v.br = br; v.tk = tk; v.ill = ill;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input vec_t v);
        int waits;
        bit acc;
        bus.in_valid = 1'b1;
        bus.opcode   = v.op;
        bus.funct3   = v.f3;
        bus.funct7_5 = v.f7;
        bus.rs1_val  = v.a;
        bus.rs2_val  = v.b;
        bus.imm      = v.imm;
        waits = 0;
        acc   = 1'b0;
        while (!acc) begin
            #1 acc = bus.in_ready;
            @(posedge clk);
            if (!acc) begin
                waits++;
                if (waits > 40) begin
                    chk("accept_timeout", 32'd0, 32'd1);
                    bus.in_valid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
        end
        sb.push_back(v);
        inflight++;
        #1;
        chk("alu_ctrl", {28'd0, bus.alu_ctrl}, {28'd0, v.ctrl});
        if (v.ill) begin
            chk("illegal_alu_a", bus.alu_a, 32'd0);
            chk("illegal_alu_b", bus.alu_b, 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || inflight != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 32'd0);
    endtask

    // Retire-side monitor: scoreboard pop, stall stability, in_ready model.
    initial begin
        bit   rdy;
        vec_t e;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                inflight       = 0;
                held_valid     = 0;
                retire_pending = 0;
                stall_full     = 0;
                bus.out_ready  = 1'b1;
                continue;
            end
            if (retire_pending) begin
                inflight--;
                retire_pending = 0;
            end
            if (stall_full) begin
                chk("stall_alu_a", bus.alu_a, s_a);
                chk("stall_alu_b", bus.alu_b, s_b);
                chk("stall_alu_ctrl", {28'd0, bus.alu_ctrl}, {28'd0, s_c});
            end
            if (bus.out_valid) begin
                if (held_valid) begin
                    chk("stall_out_result", bus.out_result, h_res);
                    chk("stall_out_flags", {29'd0, bus.out_is_branch, bus.out_taken, bus.out_illegal},
                        {29'd0, h_br, h_tk, h_ill});
                end else if (sb.size() == 0) begin
                    chk("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_result", bus.out_result, e.res);
                    chk("out_is_branch", {31'd0, bus.out_is_branch}, {31'd0, e.br});
                    chk("out_taken", {31'd0, bus.out_taken}, {31'd0, e.tk});
                    chk("out_illegal", {31'd0, bus.out_illegal}, {31'd0, e.ill});
                    h_res = bus.out_result; h_br = bus.out_is_branch;
                    h_tk = bus.out_taken; h_ill = bus.out_illegal;
                    held_valid = 1;
                end
            end
            rdy = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
            bus.out_ready = rdy;
            #1;
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, !(inflight == 2 && !rdy)});
            stall_full = bus.out_valid && !rdy && (inflight == 2);
            s_a = bus.alu_a; s_b = bus.alu_b; s_c = bus.alu_ctrl;
            if (bus.out_valid && rdy) begin
                held_valid     = 0;
                retire_pending = 1;
            end
        end
    end

    initial begin
        vec_t v;
        bus.in_valid = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.funct7_5 = 1'b0;
        bus.rs1_val = '0; bus.rs2_val = '0; bus.imm = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("reset_alu_a", bus.alu_a, 32'd0);
        chk("reset_alu_b", bus.alu_b, 32'd0);
        chk("reset_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
        chk("reset_out", {bus.out_result[27:0], bus.out_valid, bus.out_is_branch, bus.out_taken, bus.out_illegal}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        //          op          f3     f7  rs1           rs2           imm           ctrl   result        br tk ill
        tbl.push_back(mk(7'b0110011, 3'b000, 1, 32'd10,       32'd3,        32'd0,        4'h1, 32'd7,        0, 0, 0));
        tbl.push_back(mk(7'b0110011, 3'b000, 0, 32'd10,       32'd3,        32'd0,        4'h0, 32'd13,       0, 0, 0));
        tbl.push_back(mk(7'b1100011, 3'b000, 0, 32'd5,        32'd5,        32'd0,        4'h1, 32'd0,        1, 1, 0));
        tbl.push_back(mk(7'b1100011, 3'b001, 0, 32'd5,        32'd5,        32'd0,        4'h1, 32'd0,        1, 0, 0));
        tbl.push_back(mk(7'b1100011, 3'b100, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'h8, 32'd1,        1, 1, 0));
        tbl.push_back(mk(7'b1100011, 3'b101, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'h8, 32'd1,        1, 0, 0));
        tbl.push_back(mk(7'b0010011, 3'b101, 1, 32'h80000000, 32'd9,        32'd4,        4'h7, 32'hF8000000, 0, 0, 0));
        tbl.push_back(mk(7'b0010011, 3'b000, 1, 32'd5,        32'd9,        32'hFFFFFFFF, 4'h0, 32'd4,        0, 0, 0));
        tbl.push_back(mk(7'b0110011, 3'b011, 0, 32'd1,        32'd2,        32'd0,        4'h0, 32'd0,        0, 0, 1));
        tbl.push_back(mk(7'b1100011, 3'b110, 0, 32'd1,        32'd2,        32'd0,        4'h0, 32'd0,        0, 0, 1));
        tbl.push_back(mk(7'b1111111, 3'b000, 0, 32'd7,        32'd7,        32'd7,        4'h0, 32'd0,        0, 0, 1));
        tbl.push_back(mk(7'b0110111, 3'b000, 0, 32'd123,      32'd0,        32'h12345000, 4'h0, 32'h12345000, 0, 0, 0));
        tbl.push_back(mk(7'b0000011, 3'b010, 0, 32'd100,      32'd0,        32'hFFFFFFFC, 4'h0, 32'd96,       0, 0, 0));
        tbl.push_back(mk(7'b0010011, 3'b100, 0, 32'h000000F0, 32'd0,        32'h000000FF, 4'h4, 32'h0000000F, 0, 0, 0));
        tbl.push_back(mk(7'b0110011, 3'b101, 0, 32'h80000000, 32'd4,        32'd0,        4'h6, 32'h08000000, 0, 0, 0));
        tbl.push_back(mk(7'b0010011, 3'b001, 0, 32'd1,        32'd0,        32'd31,       4'h5, 32'h80000000, 0, 0, 0));
        tbl.push_back(mk(7'b0110011, 3'b110, 0, 32'h000000F0, 32'h0000000F, 32'd0,        4'h3, 32'h000000FF, 0, 0, 0));
        tbl.push_back(mk(7'b0110011, 3'b111, 0, 32'h000000F0, 32'h000000FF, 32'd0,        4'h2, 32'h000000F0, 0, 0, 0));
        tbl.push_back(mk(7'b0100011, 3'b010, 0, 32'd8,        32'd99,       32'd8,        4'h0, 32'd16,       0, 0, 0));
        foreach (tbl[i]) send(tbl[i]);
        bus.in_valid = 1'b0;
        drain();

        // Four ADDIs (results 1..4) streamed against a toggling out_ready.
        rdy_pat = '{1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1};
        for (int i = 1; i <= 4; i++) begin
            send(mk(7'b0010011, 3'b000, 0, 32'd0, 32'd0, i, 4'h0, i, 0, 0, 0));
        end
        bus.in_valid = 1'b0;
        drain();

        // Two SUBs held in flight, then reset.
        rdy_pat = '{0, 0, 0, 0, 0, 0};
        send(mk(7'b0110011, 3'b000, 1, 32'd9, 32'd1, 32'd0, 4'h1, 32'd8, 0, 0, 0));
        send(mk(7'b0110011, 3'b000, 1, 32'd9, 32'd2, 32'd0, 4'h1, 32'd7, 0, 0, 0));
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rdy_pat.delete();
        #2 rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        v = mk(7'b0110011, 3'b100, 0, 32'h0000FF00, 32'h00000FF0, 32'd0, 4'h4, 32'h0000F0F0, 0, 0, 0);
        send(v);
        bus.in_valid = 1'b0;
        #1 chk("latency_not_early", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1 chk("latency_two_cycles", {31'd0, bus.out_valid}, 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
